// File: rtl/axi_master_arb_mux_w.sv
// Write-path arbiter/mux: N AXI4 masters share one slave write port. The grant is held for a
// whole transaction (AW, all W beats through WLAST, then B) and is chosen round-robin or fixed-priority.
module axi_master_arb_mux_w #(
   parameter int NUM_MASTERS = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int ID_WIDTH    = 1,
   parameter int USER_WIDTH  = 1,
   parameter int STRB_WIDTH  = DATA_WIDTH/8,
   parameter int ARB_MODE    = 0,
   parameter int AW_W        = ID_WIDTH + ADDR_WIDTH + 29 + USER_WIDTH,
   parameter int W_W         = ID_WIDTH + DATA_WIDTH + STRB_WIDTH + 1 + USER_WIDTH
) (
   input  logic                        ACLK,
   input  logic                        ARESETn,
   input  logic [NUM_MASTERS*AW_W-1:0] m_aw_pld,
   input  logic [NUM_MASTERS-1:0]      m_awvalid,
   output logic [NUM_MASTERS-1:0]      m_awready,
   input  logic [NUM_MASTERS*W_W-1:0]  m_w_pld,
   input  logic [NUM_MASTERS-1:0]      m_wvalid,
   output logic [NUM_MASTERS-1:0]      m_wready,
   output logic [NUM_MASTERS-1:0]      m_bvalid,
   input  logic [NUM_MASTERS-1:0]      m_bready,
   output logic [AW_W-1:0]             s_aw_pld,
   output logic                        s_awvalid,
   input  logic                        s_awready,
   output logic [W_W-1:0]              s_w_pld,
   output logic                        s_wvalid,
   input  logic                        s_wready,
   input  logic                        s_bvalid,
   output logic                        s_bready,
   output logic [NUM_MASTERS-1:0]      grant
);

   localparam int IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int WLAST_BIT = USER_WIDTH;

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic                   aw_done_q, aw_done_d;
   logic                   w_done_q, w_done_d;

   logic                   win_found;
   logic [IDX_W-1:0]       win_idx;
   logic [IDX_W-1:0]       cand;
   logic                   xfer, resp;
   logic [AW_W-1:0]        own_aw_pld;
   logic [W_W-1:0]         own_w_pld;
   logic                   own_awvalid, own_wvalid, own_bready;
   logic                   aw_hs, w_last_hs, b_hs;

   // Round-robin scans from last owner + 1; fixed mode scans from index 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (ARB_MODE == 1) begin
            cand = IDX_W'(i);
         end else begin
            cand = IDX_W'((int'(last_q) + 1 + i) % NUM_MASTERS);
         end
         if (!win_found && m_awvalid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign xfer        = (state_q == XFER);
   assign resp        = (state_q == RESP);
   assign own_aw_pld  = m_aw_pld[int'(owner_q)*AW_W +: AW_W];
   assign own_w_pld   = m_w_pld[int'(owner_q)*W_W +: W_W];
   assign own_awvalid = m_awvalid[owner_q];
   assign own_wvalid  = m_wvalid[owner_q];
   assign own_bready  = m_bready[owner_q];

   assign s_awvalid = xfer & own_awvalid & ~aw_done_q;
   assign s_wvalid  = xfer & own_wvalid & ~w_done_q;
   assign s_bready  = resp & own_bready;
   assign s_aw_pld  = (state_q != IDLE) ? own_aw_pld : '0;
   assign s_w_pld   = (state_q != IDLE) ? own_w_pld : '0;
   assign grant     = grant_q;

   assign aw_hs     = s_awvalid & s_awready;
   assign w_last_hs = s_wvalid & s_wready & own_w_pld[WLAST_BIT];
   assign b_hs      = s_bvalid & s_bready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
         assign m_awready[gi] = grant_q[gi] & xfer & s_awready & ~aw_done_q;
         assign m_wready[gi]  = grant_q[gi] & xfer & s_wready & ~w_done_q;
         assign m_bvalid[gi]  = grant_q[gi] & resp & s_bvalid;
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      last_d    = last_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d   = XFER;
               grant_d   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx;
               owner_d   = win_idx;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         XFER: begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_last_hs) w_done_d = 1'b1;
            // Both halves may complete on the same edge.
            if ((aw_done_q | aw_hs) & (w_done_q | w_last_hs)) state_d = RESP;
         end
         RESP: begin
            if (b_hs) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         last_q    <= IDX_W'(NUM_MASTERS - 1);
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

endmodule

// File: tb/tb_axi_master_arb_mux_w.sv
// Bench for axi_master_arb_mux_w: a round-robin and a fixed-priority instance share the stimulus;
// per-master AW/W payload queues and an expected-owner queue are checked at the slave side.
module tb_axi_master_arb_mux_w;

   localparam int NM     = 4;
   localparam int AW_W   = 63;
   localparam int W_W    = 39;
   localparam int BUDGET = 300;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [NM*AW_W-1:0] m_aw_pld = '0;
   logic [NM*W_W-1:0]  m_w_pld = '0;
   logic [NM-1:0]      m_awvalid = '0, m_wvalid = '0, m_bready = '0;
   logic               s_awready = 1'b1, s_wready = 1'b1, s_bvalid = 1'b0;

   logic [NM-1:0]   m_awready_r, m_wready_r, m_bvalid_r, grant_r;
   logic [AW_W-1:0] s_aw_pld_r;
   logic [W_W-1:0]  s_w_pld_r;
   logic            s_awvalid_r, s_wvalid_r, s_bready_r;
   logic [NM-1:0]   m_awready_f, m_wready_f, m_bvalid_f, grant_f;
   logic [AW_W-1:0] s_aw_pld_f;
   logic [W_W-1:0]  s_w_pld_f;
   logic            s_awvalid_f, s_wvalid_f, s_bready_f;

   bit use_fixed = 1'b0;
   logic [NM-1:0]   m_awready_v, m_wready_v, m_bvalid_v, grant_v;
   logic [AW_W-1:0] s_aw_pld_v;
   logic [W_W-1:0]  s_w_pld_v;
   logic            s_awvalid_v, s_wvalid_v, s_bready_v;

   assign m_awready_v = use_fixed ? m_awready_f : m_awready_r;
   assign m_wready_v  = use_fixed ? m_wready_f  : m_wready_r;
   assign m_bvalid_v  = use_fixed ? m_bvalid_f  : m_bvalid_r;
   assign grant_v     = use_fixed ? grant_f     : grant_r;
   assign s_aw_pld_v  = use_fixed ? s_aw_pld_f  : s_aw_pld_r;
   assign s_w_pld_v   = use_fixed ? s_w_pld_f   : s_w_pld_r;
   assign s_awvalid_v = use_fixed ? s_awvalid_f : s_awvalid_r;
   assign s_wvalid_v  = use_fixed ? s_wvalid_f  : s_wvalid_r;
   assign s_bready_v  = use_fixed ? s_bready_f  : s_bready_r;

   axi_master_arb_mux_w #(.NUM_MASTERS(NM), .ARB_MODE(0)) dut_rr (
      .ACLK(clk), .ARESETn(rst_n),
      .m_aw_pld(m_aw_pld), .m_awvalid(m_awvalid), .m_awready(m_awready_r),
      .m_w_pld(m_w_pld), .m_wvalid(m_wvalid), .m_wready(m_wready_r),
      .m_bvalid(m_bvalid_r), .m_bready(m_bready),
      .s_aw_pld(s_aw_pld_r), .s_awvalid(s_awvalid_r), .s_awready(s_awready),
      .s_w_pld(s_w_pld_r), .s_wvalid(s_wvalid_r), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bready(s_bready_r), .grant(grant_r));

   axi_master_arb_mux_w #(.NUM_MASTERS(NM), .ARB_MODE(1)) dut_fx (
      .ACLK(clk), .ARESETn(rst_n),
      .m_aw_pld(m_aw_pld), .m_awvalid(m_awvalid), .m_awready(m_awready_f),
      .m_w_pld(m_w_pld), .m_wvalid(m_wvalid), .m_wready(m_wready_f),
      .m_bvalid(m_bvalid_f), .m_bready(m_bready),
      .s_aw_pld(s_aw_pld_f), .s_awvalid(s_awvalid_f), .s_awready(s_awready),
      .s_w_pld(s_w_pld_f), .s_wvalid(s_wvalid_f), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bready(s_bready_f), .grant(grant_f));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   logic [AW_W-1:0] exp_aw [NM][$];
   logic [W_W-1:0]  exp_w  [NM][$];
   int exp_order[$];
   int bcount [NM];
   int w_fwd [NM];
   int seq_cnt [NM];
   int b_delay = 0;

   function automatic logic [AW_W-1:0] mk_aw(input int m, input int seq, input int nb);
      logic [31:0] a;
      a = {8'(m), 8'(seq), 16'h1000};
      return {1'(m), a, 8'(nb - 1), 3'd2, 2'b01, 1'b0, 4'h3, 3'd0, 4'(m), 4'd0, 1'(seq)};
   endfunction

   function automatic logic [W_W-1:0] mk_w(input int m, input int seq, input int b, input bit last);
      logic [31:0] d;
      d = {8'(m), 8'(seq), 16'(b)};
      return {1'(m), d, 4'hf, last, 1'(b)};
   endfunction

   // Slave: asserts BVALID b_delay cycles after it has seen both the AW and the last W beat.
   bit aw_seen, wl_seen, bhs;
   int bcnt;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            aw_seen = 0; wl_seen = 0; bhs = 0; bcnt = 0;
         end else begin
            if (s_awvalid_v && s_awready) aw_seen = 1;
            if (s_wvalid_v && s_wready && s_w_pld_v[1]) wl_seen = 1;
            bhs = s_bvalid && s_bready_v;
         end
         @(posedge clk); #1;
         if (bhs) begin s_bvalid = 0; bhs = 0; end
         if (aw_seen && wl_seen && !s_bvalid) begin
            if (bcnt >= b_delay) begin
               s_bvalid = 1; aw_seen = 0; wl_seen = 0; bcnt = 0;
            end else begin
               bcnt++;
            end
         end
         if (!rst_n) s_bvalid = 0;
      end
   end

   // Scoreboard: pops expected payloads/owners when the slave side accepts them.
   always @(negedge clk) begin
      int own;
      logic [AW_W-1:0] ea;
      logic [W_W-1:0] ew;
      int eo;
      n_checks++;
      if (((m_awready_v | m_wready_v | m_bvalid_v) & ~grant_v) !== '0) begin
         n_fail++;
         $display("FAIL gating: rdy/bvalid aw=%b w=%b b=%b grant=%b required none outside grant",
                  m_awready_v, m_wready_v, m_bvalid_v, grant_v);
      end
      own = 0;
      for (int i = 0; i < NM; i++) if (grant_v[i]) own = i;
      if (s_awvalid_v && s_awready) begin
         n_checks++;
         if ($countones(grant_v) != 1 || exp_aw[own].size() == 0) begin
            n_fail++;
            $display("FAIL aw_owner: grant=%b queued=%0d required one-hot owner with pending AW", grant_v, exp_aw[own].size());
         end else begin
            ea = exp_aw[own].pop_front();
            if (s_aw_pld_v !== ea) begin
               n_fail++;
               $display("FAIL aw_payload m%0d: got %h required %h", own, s_aw_pld_v, ea);
            end
            $display("AW  m%0d payload %h", own, s_aw_pld_v);
            if (exp_order.size() != 0) begin
               eo = exp_order.pop_front();
               n_checks++;
               if (own != eo) begin
                  n_fail++;
                  $display("FAIL grant_order: got m%0d required m%0d", own, eo);
               end
            end
         end
      end
      if (s_wvalid_v && s_wready) begin
         n_checks++;
         if ($countones(grant_v) != 1 || exp_w[own].size() == 0) begin
            n_fail++;
            $display("FAIL w_owner: grant=%b queued=%0d required one-hot owner with pending W", grant_v, exp_w[own].size());
         end else begin
            ew = exp_w[own].pop_front();
            w_fwd[own]++;
            if (s_w_pld_v !== ew) begin
               n_fail++;
               $display("FAIL w_payload m%0d: got %h required %h", own, s_w_pld_v, ew);
            end
            $display("W   m%0d payload %h", own, s_w_pld_v);
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 0;
      m_awvalid = '0; m_wvalid = '0; m_bready = '0;
      s_awready = 1; s_wready = 1; b_delay = 0;
      for (int i = 0; i < NM; i++) begin
         exp_aw[i].delete(); exp_w[i].delete();
         bcount[i] = 0; w_fwd[i] = 0; seq_cnt[i] = 0;
      end
      exp_order.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   // One master transaction: AW after aw_delay cycles, nb W beats in parallel, then B after b_hold cycles.
   task automatic master_txn(input int m, input int nb, input int aw_delay, input int b_hold);
      logic [AW_W-1:0] aw;
      int seq;
      bit hs_aw, hs_w, hs_b, hs;
      seq = seq_cnt[m];
      seq_cnt[m]++;
      hs_aw = 0; hs_w = 1;
      fork
         begin
            repeat (aw_delay) begin @(posedge clk); #1; end
            aw = mk_aw(m, seq, nb);
            m_aw_pld[m*AW_W +: AW_W] = aw;
            exp_aw[m].push_back(aw);
            m_awvalid[m] = 1'b1;
            for (int c = 0; c < BUDGET; c++) begin
               @(negedge clk); hs_aw = m_awready_v[m];
               @(posedge clk); #1;
               if (hs_aw) break;
            end
            m_awvalid[m] = 1'b0;
         end
         begin
            for (int b = 0; b < nb; b++) begin
               logic [W_W-1:0] wp;
               bit hs_beat;
               hs_beat = 0;
               wp = mk_w(m, seq, b, b == nb - 1);
               m_w_pld[m*W_W +: W_W] = wp;
               exp_w[m].push_back(wp);
               m_wvalid[m] = 1'b1;
               for (int c = 0; c < BUDGET; c++) begin
                  @(negedge clk); hs_beat = m_wready_v[m];
                  @(posedge clk); #1;
                  if (hs_beat) break;
               end
               if (!hs_beat) hs_w = 0;
            end
            m_wvalid[m] = 1'b0;
         end
      join
      n_checks++;
      if (!hs_aw || !hs_w) begin
         n_fail++;
         $display("FAIL txn_timeout m%0d: aw_done=%0d w_done=%0d required 1/1", m, hs_aw, hs_w);
         return;
      end
      hs_b = 0;
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge clk);
         if (m_bvalid_v[m]) begin hs_b = 1; break; end
         @(posedge clk); #1;
      end
      n_checks++;
      if (!hs_b) begin
         n_fail++;
         $display("FAIL b_timeout m%0d: bvalid=0 required 1", m);
         return;
      end
      for (int h = 0; h < b_hold; h++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++;
         if (m_bvalid_v[m] !== 1'b1 || grant_v[m] !== 1'b1) begin
            n_fail++;
            $display("FAIL b_hold m%0d: bvalid=%b grant=%b required bvalid=1 with grant held", m, m_bvalid_v[m], grant_v);
         end
      end
      @(posedge clk); #1;
      m_bready[m] = 1'b1;
      @(negedge clk);
      hs = m_bvalid_v[m];
      n_checks++;
      if (!hs) begin
         n_fail++;
         $display("FAIL b_handshake m%0d: bvalid=%b required 1", m, hs);
      end
      @(posedge clk); #1;
      m_bready[m] = 1'b0;
      bcount[m]++;
      $display("B   m%0d seq %0d", m, seq);
      n_checks++;
      if (grant_v !== '0) begin
         n_fail++;
         $display("FAIL grant_release m%0d: grant=%b required 0000", m, grant_v);
      end
   endtask

   task automatic test_reset();
      use_fixed = 0;
      rst_n = 0;
      m_awvalid = '1; m_wvalid = '1; m_bready = '1;
      s_awready = 1; s_wready = 1;
      for (int i = 0; i < NM; i++) begin
         m_aw_pld[i*AW_W +: AW_W] = mk_aw(i, 5, 4);
         m_w_pld[i*W_W +: W_W] = mk_w(i, 5, 0, 1);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({grant_v, m_awready_v, m_wready_v, m_bvalid_v} !== '0 ||
          {s_awvalid_v, s_wvalid_v, s_bready_v} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: grant=%b awr=%b wr=%b bv=%b s_v=%b%b%b required all 0",
                  grant_v, m_awready_v, m_wready_v, m_bvalid_v, s_awvalid_v, s_wvalid_v, s_bready_v);
      end
      n_checks++;
      if (s_aw_pld_v !== '0 || s_w_pld_v !== '0) begin
         n_fail++;
         $display("FAIL reset_pld: aw=%h w=%h required 0", s_aw_pld_v, s_w_pld_v);
      end
      s_awready = 0; s_wready = 0;
      rst_n = 1;
      @(posedge clk); #1;
      n_checks++;
      if (grant_v !== 4'b0001 || s_awvalid_v !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_grant: grant=%b s_awvalid=%b required 0001/1", grant_v, s_awvalid_v);
      end
      $display("RST first grant %b", grant_v);
      m_awvalid = '0; m_wvalid = '0; m_bready = '0;
   endtask

   task automatic test_rr_order();
      use_fixed = 0;
      do_reset();
      exp_order = '{0, 1, 2, 3, 0};
      fork
         begin master_txn(0, 4, 0, 0); master_txn(0, 4, 0, 0); end
         master_txn(1, 4, 0, 0);
         master_txn(2, 4, 0, 0);
         master_txn(3, 4, 0, 0);
      join
      for (int i = 0; i < NM; i++) begin
         n_checks++;
         if (w_fwd[i] != ((i == 0) ? 8 : 4) || bcount[i] != ((i == 0) ? 2 : 1) ||
             exp_w[i].size() != 0 || exp_aw[i].size() != 0) begin
            n_fail++;
            $display("FAIL rr_counts m%0d: beats=%0d b=%0d left=%0d required %0d/%0d/0",
                     i, w_fwd[i], bcount[i], exp_w[i].size(), (i == 0) ? 8 : 4, (i == 0) ? 2 : 1);
         end
      end
      n_checks++;
      if (exp_order.size() != 0) begin
         n_fail++;
         $display("FAIL rr_order_left: %0d grants unseen required 0", exp_order.size());
      end
   endtask

   task automatic test_w_before_aw();
      bit ok;
      use_fixed = 0;
      do_reset();
      s_awready = 0;
      fork
         master_txn(2, 2, 3, 0);
         begin
            ok = 0;
            for (int c = 0; c < BUDGET; c++) begin
               @(negedge clk);
               if (w_fwd[2] == 2) begin ok = 1; break; end
            end
            n_checks++;
            if (!ok) begin
               n_fail++;
               $display("FAIL wfirst_fwd: beats=%0d required 2", w_fwd[2]);
            end
            @(posedge clk); #1;
            repeat (2) begin
               @(negedge clk);
               n_checks++;
               if (grant_v !== 4'b0100 || s_awvalid_v !== 1'b1 || s_wvalid_v !== 1'b0 || m_bvalid_v !== '0) begin
                  n_fail++;
                  $display("FAIL wfirst_xfer: grant=%b s_awvalid=%b s_wvalid=%b bvalid=%b required 0100/1/0/0000",
                           grant_v, s_awvalid_v, s_wvalid_v, m_bvalid_v);
               end
            end
            @(posedge clk); #1;
            s_awready = 1;
         end
      join
      n_checks++;
      if (bcount[2] != 1 || exp_aw[2].size() != 0) begin
         n_fail++;
         $display("FAIL wfirst_done: b=%0d aw_left=%0d required 1/0", bcount[2], exp_aw[2].size());
      end
   endtask

   task automatic test_same_cycle_b_hold();
      bit ok;
      use_fixed = 0;
      do_reset();
      b_delay = 3;
      fork
         master_txn(1, 1, 0, 2);
         begin
            ok = 0;
            for (int c = 0; c < BUDGET; c++) begin
               @(negedge clk);
               if (s_awvalid_v && s_awready) begin
                  ok = 1;
                  n_checks++;
                  if (!(s_wvalid_v && s_wready && s_w_pld_v[1])) begin
                     n_fail++;
                     $display("FAIL same_cycle: wvalid=%b wlast=%b required 1/1", s_wvalid_v, s_w_pld_v[1]);
                  end
                  break;
               end
            end
            n_checks++;
            if (!ok) begin
               n_fail++;
               $display("FAIL same_cycle_aw: aw handshake=0 required 1");
            end
         end
      join
      n_checks++;
      if (bcount[1] != 1) begin
         n_fail++;
         $display("FAIL same_cycle_b: b=%0d required 1", bcount[1]);
      end
   endtask

   task automatic test_fixed_priority();
      use_fixed = 1;
      do_reset();
      exp_order = '{1, 1, 1, 3};
      fork
         begin master_txn(1, 2, 0, 0); master_txn(1, 2, 0, 0); master_txn(1, 2, 0, 0); end
         master_txn(3, 2, 0, 0);
      join
      n_checks++;
      if (exp_order.size() != 0 || bcount[1] != 3 || bcount[3] != 1) begin
         n_fail++;
         $display("FAIL fixed_prio: unseen=%0d b1=%0d b3=%0d required 0/3/1", exp_order.size(), bcount[1], bcount[3]);
      end
      use_fixed = 0;
   endtask

   task automatic test_reset_mid_burst();
      logic [AW_W-1:0] aw;
      logic [W_W-1:0] wp;
      use_fixed = 0;
      do_reset();
      aw = mk_aw(1, 0, 4);
      m_aw_pld[1*AW_W +: AW_W] = aw;
      exp_aw[1].push_back(aw);
      m_awvalid[1] = 1;
      wp = mk_w(1, 0, 0, 0);
      m_w_pld[1*W_W +: W_W] = wp;
      exp_w[1].push_back(wp);
      m_wvalid[1] = 1;
      @(posedge clk); #1;
      n_checks++;
      if (grant_v !== 4'b0010) begin
         n_fail++;
         $display("FAIL midrst_grant: grant=%b required 0010", grant_v);
      end
      @(posedge clk); #1;
      m_awvalid[1] = 0;
      wp = mk_w(1, 0, 1, 0);
      m_w_pld[1*W_W +: W_W] = wp;
      exp_w[1].push_back(wp);
      #1;
      n_checks++;
      if (s_wvalid_v !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_beat2: s_wvalid=%b required 1", s_wvalid_v);
      end
      rst_n = 0;
      #1;
      n_checks++;
      if (grant_v !== '0 || s_wvalid_v !== 1'b0 || m_wready_v !== '0 || s_w_pld_v !== '0) begin
         n_fail++;
         $display("FAIL midrst_clear: grant=%b s_wvalid=%b wready=%b pld=%h required 0",
                  grant_v, s_wvalid_v, m_wready_v, s_w_pld_v);
      end
      $display("RST mid-burst grant %b s_wvalid %b", grant_v, s_wvalid_v);
      m_wvalid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      exp_aw[1].delete(); exp_w[1].delete();
      exp_order.push_back(2);
      master_txn(2, 2, 0, 0);
      n_checks++;
      if (bcount[2] != 1 || exp_order.size() != 0) begin
         n_fail++;
         $display("FAIL midrst_next: b=%0d unseen=%0d required 1/0", bcount[2], exp_order.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rr_order();
      test_w_before_aw();
      test_same_cycle_b_hold();
      test_fixed_priority();
      test_reset_mid_burst();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
